mul_cyc_ctrl_fsm: RTL and testbench
===================================

// Module: mul_cyc_ctrl_fsm
// PURPOSE
//  Parametrised variable-length control FSM for the multi-cycle CPU. Steps IF/ID/EX/MEM/WB,
//  skipping phases an opcode does not need. Stalls on a memory ready handshake, traps on illegal
//  opcodes and counts retired instructions. Sits between the IR/register file/ALU/memory datapath.
// PARAMETERS
//  OPC_W    6   opcode field width (irOutOpe)
//  FUNCT_W  6   ALU function code width (irFunct, funct)
//  CNT_W    16  retired-instruction counter width
// PORTS
//  clk       in   1        clock, rising edge
//  rst       in   1        asynchronous, active-low reset
//  irOutOpe  in   OPC_W    opcode from IR; stable from ID onward
//  irFunct   in   FUNCT_W  R-type function field from IR
//  memRdy    in   1        memory completes current IF/MEM access this cycle
//  aluZero   in   1        ALU zero flag (valid in EX)
//  memReq    out  1        memory access request (IF and MEM)
//  fecAbl    out  1        PC+4 write-enable pulse at fetch completion
//  irWr      out  1        IR load at fetch completion
//  regWr     out  1        register-file write (WB)
//  aluSrcB   out  1        1 = immediate to ALU B
//  memToReg  out  1        1 = WB data from memory
//  datMemWr  out  1        data-memory write (sw, MEM)
//  pcWr      out  1        branch/jump PC write
//  pcSrc     out  2        00 PC+4, 01 branch target, 10 jump target
//  funct     out  FUNCT_W  ALU operation code
//  state     out  3        IF=0 ID=1 EX=2 MEM=3 WB=4 TRAP=7
//  retire    out  1        last cycle of an instruction
//  trap      out  1        illegal opcode; sticky until reset
//  instCnt   out  CNT_W    retired-instruction count
// BEHAVIOUR
//  - Reset: state=IF, instCnt=0, trap=0. While rst=0, every output is forced 0, including memReq.
//    The first memReq is asserted in the first cycle after rst rises.
//  - State is registered. Outputs are combinational from state, irOutOpe, memRdy and aluZero.
//  - Opcodes: R 000000, addi 001000, lw 100011, sw 101011, beq 000100, j 000010. Others are illegal.
//  - Paths, in cycles excluding stalls: R/addi IF-ID-EX-WB (4); lw IF-ID-EX-MEM-WB (5);
//    sw IF-ID-EX-MEM (4); beq IF-ID-EX (3); j IF-ID (2); illegal IF-ID-TRAP.
//  - IF: memReq=1. The FSM holds IF while memRdy=0. When memRdy=1: fecAbl=irWr=1, pcSrc=00, next state ID.
//  - ID: decode only.
//      - j: pcWr=1, pcSrc=10, retire=1, next state IF.
//      - illegal: next state TRAP.
//  - EX: funct selection:
//      - R-type: funct=irFunct.
//      - addi/lw/sw: funct=6'b100000 (ADD) and aluSrcB=1.
//      - beq: funct=6'b100010 (SUB), pcSrc=01, pcWr=aluZero, retire=1, next state IF.
//      - funct=0 outside EX.
//  - MEM: memReq=1, datMemWr=1 for sw only. The FSM holds MEM while memRdy=0.
//      - On memRdy: lw goes to WB; sw sets retire=1 and goes to IF.
//      - datMemWr stays asserted through the stall.
//  - WB: regWr=1, memToReg=1 for lw only, retire=1, next state IF.
//  - TRAP: trap=1, all enables 0, memReq=0. Held until reset, irrespective of inputs.
//  - memRdy is ignored outside IF and MEM. aluZero is ignored outside EX.
//  - instCnt increments on every clock where retire=1 and wraps 2^CNT_W-1 -> 0. Illegal ops never retire.
//  - A reset asserted mid-instruction aborts it at once. instCnt does not count the aborted instruction.
//  - Enable outputs are single-cycle per instruction, except datMemWr and memReq, which hold through stalls.
// TESTING
//  1. Reset release, memRdy=1, R-type irFunct=100100 -> states 0,1,2,4.
//     funct=100100 in EX; regWr=1 and retire=1 in WB; instCnt=1.
//  2. lw with memRdy low for 3 cycles in MEM -> MEM held 4 cycles with memReq=1.
//     WB memToReg=1; total 8 cycles.
//  3. beq with aluZero=1, then aluZero=0 -> pcWr=1/pcSrc=01 the first time, pcWr=0 the second.
//     Each takes 3 cycles.
//  4. j back-to-back with sw -> j retires in ID with pcSrc=10.
//     sw asserts datMemWr only in MEM, then returns to IF.
//  5. Opcode 111111 -> TRAP (state=7), trap=1 sticky over 20 cycles, instCnt unchanged.
//     rst low clears trap and instCnt=0.
//  6. CNT_W=4, 17 j instructions -> instCnt wraps 15 -> 0 -> 1.
//     Separately, rst pulse during MEM stall -> outputs 0 at once, restart in IF.

Source files
------------

// File: rtl/mul_cyc_ctrl_fsm.sv
// Variable-length IF/ID/EX/MEM/WB control FSM for the multi-cycle CPU.
// Phases an opcode does not need are skipped; memory stalls hold IF/MEM, illegal opcodes trap.
module mul_cyc_ctrl_fsm #(
    parameter int OPC_W   = 6,
    parameter int FUNCT_W = 6,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OPC_W-1:0]   irOutOpe,
    input  logic [FUNCT_W-1:0] irFunct,
    input  logic               memRdy,
    input  logic               aluZero,
    output logic               memReq,
    output logic               fecAbl,
    output logic               irWr,
    output logic               regWr,
    output logic               aluSrcB,
    output logic               memToReg,
    output logic               datMemWr,
    output logic               pcWr,
    output logic [1:0]         pcSrc,
    output logic [FUNCT_W-1:0] funct,
    output logic [2:0]         state,
    output logic               retire,
    output logic               trap,
    output logic [CNT_W-1:0]   instCnt
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd7
    } state_t;

    typedef struct packed {
        logic               memReq;
        logic               fecAbl;
        logic               irWr;
        logic               regWr;
        logic               aluSrcB;
        logic               memToReg;
        logic               datMemWr;
        logic               pcWr;
        logic [1:0]         pcSrc;
        logic [FUNCT_W-1:0] funct;
        logic               retire;
        logic               trap;
    } ctrl_t;

    localparam logic [OPC_W-1:0]   OP_R    = OPC_W'(6'b000000);
    localparam logic [OPC_W-1:0]   OP_ADDI = OPC_W'(6'b001000);
    localparam logic [OPC_W-1:0]   OP_LW   = OPC_W'(6'b100011);
    localparam logic [OPC_W-1:0]   OP_SW   = OPC_W'(6'b101011);
    localparam logic [OPC_W-1:0]   OP_BEQ  = OPC_W'(6'b000100);
    localparam logic [OPC_W-1:0]   OP_J    = OPC_W'(6'b000010);
    localparam logic [FUNCT_W-1:0] FN_ADD  = FUNCT_W'(6'b100000);
    localparam logic [FUNCT_W-1:0] FN_SUB  = FUNCT_W'(6'b100010);

    state_t cur, nxt;
    ctrl_t  ctl, ctl_out;

    logic is_r, is_addi, is_lw, is_sw, is_beq, is_j, is_legal;

    assign is_r     = (irOutOpe == OP_R);
    assign is_addi  = (irOutOpe == OP_ADDI);
    assign is_lw    = (irOutOpe == OP_LW);
    assign is_sw    = (irOutOpe == OP_SW);
    assign is_beq   = (irOutOpe == OP_BEQ);
    assign is_j     = (irOutOpe == OP_J);
    assign is_legal = is_r | is_addi | is_lw | is_sw | is_beq | is_j;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cur <= S_IF;
        else      cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        ctl = '0;
        case (cur)
            S_IF: begin
                ctl.memReq = 1'b1;
                if (memRdy) begin
                    ctl.fecAbl = 1'b1;
                    ctl.irWr   = 1'b1;
                    nxt        = S_ID;
                end
            end
            S_ID: begin
                if (is_j) begin
                    ctl.pcWr   = 1'b1;
                    ctl.pcSrc  = 2'b10;
                    ctl.retire = 1'b1;
                    nxt        = S_IF;
                end else if (!is_legal) begin
                    nxt = S_TRAP;
                end else begin
                    nxt = S_EX;
                end
            end
            S_EX: begin
                if (is_r) begin
                    ctl.funct = irFunct;
                    nxt       = S_WB;
                end else if (is_addi || is_lw || is_sw) begin
                    ctl.funct   = FN_ADD;
                    ctl.aluSrcB = 1'b1;
                    nxt         = is_addi ? S_WB : S_MEM;
                end else if (is_beq) begin
                    ctl.funct  = FN_SUB;
                    ctl.pcSrc  = 2'b01;
                    ctl.pcWr   = aluZero;
                    ctl.retire = 1'b1;
                    nxt        = S_IF;
                end else begin
                    // IR changed under us after decode: drop the instruction, refetch
                    nxt = S_IF;
                end
            end
            S_MEM: begin
                ctl.memReq   = 1'b1;
                ctl.datMemWr = is_sw;
                if (memRdy) begin
                    if (is_lw) begin
                        nxt = S_WB;
                    end else begin
                        ctl.retire = is_sw;
                        nxt        = S_IF;
                    end
                end
            end
            S_WB: begin
                ctl.regWr    = 1'b1;
                ctl.memToReg = is_lw;
                ctl.retire   = 1'b1;
                nxt          = S_IF;
            end
            S_TRAP: begin
                ctl.trap = 1'b1;
            end
            default: nxt = S_IF;
        endcase
    end

    // Reset gates the outputs combinationally so nothing (memReq included) leaks while rst is low.
    assign ctl_out  = rst ? ctl : '0;
    assign memReq   = ctl_out.memReq;
    assign fecAbl   = ctl_out.fecAbl;
    assign irWr     = ctl_out.irWr;
    assign regWr    = ctl_out.regWr;
    assign aluSrcB  = ctl_out.aluSrcB;
    assign memToReg = ctl_out.memToReg;
    assign datMemWr = ctl_out.datMemWr;
    assign pcWr     = ctl_out.pcWr;
    assign pcSrc    = ctl_out.pcSrc;
    assign funct    = ctl_out.funct;
    assign retire   = ctl_out.retire;
    assign trap     = ctl_out.trap;
    assign state    = rst ? cur : S_IF;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            instCnt <= '0;
        else if (ctl.retire) instCnt <= instCnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_mul_cyc_ctrl_fsm.sv
// Bench for mul_cyc_ctrl_fsm: vector table, directed corner sequences and a random run
// checked against a path-list reference model (plus a CNT_W=4 copy for counter wrap).
module tb_mul_cyc_ctrl_fsm;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] irOutOpe = '0, irFunct = '0;
    logic       memRdy = 1'b0, aluZero = 1'b0;

    logic       memReq, fecAbl, irWr, regWr, aluSrcB, memToReg, datMemWr, pcWr, retire, trap;
    logic [1:0] pcSrc;
    logic [5:0] funct;
    logic [2:0] state;
    logic [15:0] instCnt;

    logic       b_memReq, b_fecAbl, b_irWr, b_regWr, b_aluSrcB, b_memToReg, b_datMemWr, b_pcWr;
    logic       b_retire, b_trap;
    logic [1:0] b_pcSrc;
    logic [5:0] b_funct;
    logic [2:0] b_state;
    logic [3:0] b_instCnt;

    mul_cyc_ctrl_fsm #(.OPC_W(6), .FUNCT_W(6), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .irOutOpe(irOutOpe), .irFunct(irFunct), .memRdy(memRdy),
        .aluZero(aluZero), .memReq(memReq), .fecAbl(fecAbl), .irWr(irWr), .regWr(regWr),
        .aluSrcB(aluSrcB), .memToReg(memToReg), .datMemWr(datMemWr), .pcWr(pcWr),
        .pcSrc(pcSrc), .funct(funct), .state(state), .retire(retire), .trap(trap),
        .instCnt(instCnt)
    );

    mul_cyc_ctrl_fsm #(.OPC_W(6), .FUNCT_W(6), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .irOutOpe(irOutOpe), .irFunct(irFunct), .memRdy(memRdy),
        .aluZero(aluZero), .memReq(b_memReq), .fecAbl(b_fecAbl), .irWr(b_irWr), .regWr(b_regWr),
        .aluSrcB(b_aluSrcB), .memToReg(b_memToReg), .datMemWr(b_datMemWr), .pcWr(b_pcWr),
        .pcSrc(b_pcSrc), .funct(b_funct), .state(b_state), .retire(b_retire), .trap(b_trap),
        .instCnt(b_instCnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        memReq, fecAbl, irWr, regWr, aluSrcB, memToReg, datMemWr, pcWr;
        logic [1:0]  pcSrc;
        logic [5:0]  funct;
        logic [2:0]  state;
        logic        retire, trap;
        logic [15:0] cnt;
        logic [3:0]  cnt4;
    } obs_t;

    typedef struct packed {
        logic [5:0]  op, fn;
        logic        rdy, zero;
        logic [2:0]  st;
        logic        mreq, rwr, pwr;
        logic [1:0]  psrc;
        logic [5:0]  fct;
        logic        ret;
        logic [15:0] cnt;
    } vec_t;

    int   n_chk = 0, n_fail = 0, cyc = 0;
    int   m_pos = 0, m_cnt = 0;
    logic [5:0] m_op = '0;
    obs_t obs;

    // Phase list each opcode walks through, one entry per non-stalled cycle.
    function automatic int path_at(logic [5:0] op, int i);
        int p[5];
        int n;
        case (op)
            OP_R, OP_ADDI: begin p = '{0, 1, 2, 4, 0}; n = 4; end
            OP_LW:         begin p = '{0, 1, 2, 3, 4}; n = 5; end
            OP_SW:         begin p = '{0, 1, 2, 3, 0}; n = 4; end
            OP_BEQ:        begin p = '{0, 1, 2, 0, 0}; n = 3; end
            OP_J:          begin p = '{0, 1, 0, 0, 0}; n = 2; end
            default:       begin p = '{0, 1, 7, 0, 0}; n = 3; end
        endcase
        return (i < n) ? p[i] : -1;
    endfunction

    function automatic logic [5:0] cur_op(logic [5:0] op);
        return (m_pos <= 1) ? op : m_op;
    endfunction

    function automatic int m_phase(logic [5:0] op);
        return (m_pos == 0) ? 0 : path_at(cur_op(op), m_pos);
    endfunction

    function automatic obs_t model_exp(logic [5:0] op, logic [5:0] fn, logic rdy, logic zero);
        obs_t e;
        logic [5:0] o;
        int ph;
        logic stall;
        o = cur_op(op);
        ph = m_phase(op);
        stall = ((ph == 0) || (ph == 3)) && !rdy;
        e = '0;
        e.memReq   = (ph == 0) || (ph == 3);
        e.fecAbl   = (ph == 0) && rdy;
        e.irWr     = (ph == 0) && rdy;
        e.regWr    = (ph == 4);
        e.aluSrcB  = (ph == 2) && (o == OP_ADDI || o == OP_LW || o == OP_SW);
        e.memToReg = (ph == 4) && (o == OP_LW);
        e.datMemWr = (ph == 3) && (o == OP_SW);
        e.pcWr     = ((ph == 1) && (o == OP_J)) || ((ph == 2) && (o == OP_BEQ) && zero);
        e.pcSrc    = ((ph == 1) && (o == OP_J)) ? 2'b10 : ((ph == 2) && (o == OP_BEQ)) ? 2'b01 : 2'b00;
        e.funct    = (ph != 2) ? 6'd0 : (o == OP_R) ? fn : (o == OP_BEQ) ? FN_SUB : FN_ADD;
        e.state    = 3'(ph);
        e.retire   = (ph != 7) && !stall && (path_at(o, m_pos + 1) < 0);
        e.trap     = (ph == 7);
        e.cnt      = 16'(m_cnt);
        e.cnt4     = 4'(m_cnt);
        return e;
    endfunction

    task automatic model_adv(logic [5:0] op, logic rdy);
        logic [5:0] o;
        int ph;
        o = cur_op(op);
        ph = m_phase(op);
        if (ph == 7) return;
        if (((ph == 0) || (ph == 3)) && !rdy) return;
        if (m_pos == 1) m_op = op;
        if (path_at(o, m_pos + 1) < 0) begin
            m_pos = 0;
            m_cnt++;
        end else begin
            m_pos++;
        end
    endtask

    function automatic obs_t dut_obs();
        obs_t a;
        a = '{memReq, fecAbl, irWr, regWr, aluSrcB, memToReg, datMemWr, pcWr,
              pcSrc, funct, state, retire, trap, instCnt, b_instCnt};
        return a;
    endfunction

    task automatic chk_obs(string name, obs_t a, obs_t e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, a, e);
        end
    endtask

    task automatic chk_int(string name, int a, int e);
        n_chk++;
        if (a != e) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, a, e);
        end
    endtask

    // Drive one cycle, compare against the model mid-cycle, then cross the clock edge.
    task automatic step(logic [5:0] op, logic [5:0] fn, logic rdy, logic zero, string name);
        obs_t e;
        irOutOpe = op; irFunct = fn; memRdy = rdy; aluZero = zero;
        @(negedge clk);
        e   = model_exp(op, fn, rdy, zero);
        obs = dut_obs();
        chk_obs(name, obs, e);
        model_adv(op, rdy);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(string name);
        rst = 1'b0;
        #1;
        chk_obs(name, dut_obs(), '0);
        m_pos = 0;
        m_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    function automatic vec_t mkv(logic [5:0] op, logic rdy, logic zero, logic [2:0] st,
                                 logic mreq, logic rwr, logic pwr, logic [1:0] psrc,
                                 logic [5:0] fct, logic ret, logic [15:0] cnt);
        vec_t v;
        v = '{op, 6'b100100, rdy, zero, st, mreq, rwr, pwr, psrc, fct, ret, cnt};
        return v;
    endfunction

    initial begin
        vec_t tbl[12];
        logic [2:0] lw_st[8];
        logic       lw_rdy[8];
        logic [5:0] instr;
        int         trap_cyc;
        int         cnt_before;

        tbl[0]  = mkv(OP_R,   1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 2'b00, 6'd0,   1'b0, 16'd0);
        tbl[1]  = mkv(OP_R,   1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 2'b00, 6'd0,   1'b0, 16'd0);
        tbl[2]  = mkv(OP_R,   1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 2'b00, 6'b100100, 1'b0, 16'd0);
        tbl[3]  = mkv(OP_R,   1'b1, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0, 2'b00, 6'd0,   1'b1, 16'd0);
        tbl[4]  = mkv(OP_BEQ, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 2'b00, 6'd0,   1'b0, 16'd1);
        tbl[5]  = mkv(OP_BEQ, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 2'b00, 6'd0,   1'b0, 16'd1);
        tbl[6]  = mkv(OP_BEQ, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 2'b01, FN_SUB, 1'b1, 16'd1);
        tbl[7]  = mkv(OP_BEQ, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 2'b00, 6'd0,   1'b0, 16'd2);
        tbl[8]  = mkv(OP_BEQ, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 2'b00, 6'd0,   1'b0, 16'd2);
        tbl[9]  = mkv(OP_BEQ, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 2'b01, FN_SUB, 1'b1, 16'd2);
        tbl[10] = mkv(OP_BEQ, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 2'b00, 6'd0,   1'b0, 16'd3);
        tbl[11] = mkv(OP_BEQ, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 2'b00, 6'd0,   1'b0, 16'd3);

        #2;
        do_reset("reset_init");

        // R-type then two beq (taken / not taken), then an IF stall
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].op, tbl[i].fn, tbl[i].rdy, tbl[i].zero, "tbl_model");
            chk_obs("tbl_vec", obs,
                    '{tbl[i].mreq, obs.fecAbl, obs.irWr, tbl[i].rwr, obs.aluSrcB, obs.memToReg,
                      obs.datMemWr, tbl[i].pwr, tbl[i].psrc, tbl[i].fct, tbl[i].st, tbl[i].ret,
                      1'b0, tbl[i].cnt, obs.cnt4});
        end

        // lw with three MEM stall cycles: 8 cycles total
        lw_st  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
        lw_rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            step(OP_LW, 6'd0, lw_rdy[i], 1'b0, "lw_model");
            chk_int("lw_state", int'(obs.state), int'(lw_st[i]));
            if (lw_st[i] == 3'd3) chk_int("lw_mem_memreq", int'(obs.memReq), 1);
        end
        chk_int("lw_wb_memtoreg", int'(obs.memToReg), 1);
        chk_int("lw_wb_retire", int'(obs.retire), 1);

        // j back to back with sw
        step(OP_J, 6'd0, 1'b1, 1'b0, "j_if");
        step(OP_J, 6'd0, 1'b1, 1'b0, "j_id");
        chk_int("j_pcsrc", int'(obs.pcSrc), 2);
        chk_int("j_retire", int'(obs.retire), 1);
        lw_st  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd0, 3'd0, 3'd0};
        lw_rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            step(OP_SW, 6'd0, lw_rdy[i], 1'b0, "sw_model");
            chk_int("sw_state", int'(obs.state), int'(lw_st[i]));
            chk_int("sw_datmemwr", int'(obs.datMemWr), (lw_st[i] == 3'd3) ? 1 : 0);
        end

        // illegal opcode traps and stays trapped regardless of inputs
        step(OP_BAD, 6'd0, 1'b1, 1'b0, "trap_if");
        step(OP_BAD, 6'd0, 1'b1, 1'b0, "trap_id");
        cnt_before = int'(instCnt);
        for (int i = 0; i < 20; i++) begin
            step(6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom), "trap_hold");
            chk_int("trap_state", int'(obs.state), 7);
            chk_int("trap_flag", int'(obs.trap), 1);
        end
        chk_int("trap_cnt", int'(instCnt), cnt_before);
        do_reset("trap_reset");
        step(OP_R, 6'd0, 1'b0, 1'b0, "post_trap_if");
        chk_int("post_trap_cnt", int'(obs.cnt), 0);

        // 17 j instructions: the 4-bit counter wraps 15 -> 0 -> 1
        do_reset("wrap_reset");
        for (int k = 1; k <= 17; k++) begin
            step(OP_J, 6'd0, 1'b1, 1'b0, "wrap_if");
            step(OP_J, 6'd0, 1'b1, 1'b0, "wrap_id");
            if (k == 15) chk_int("wrap_15", int'(b_instCnt), 15);
            if (k == 16) chk_int("wrap_0", int'(b_instCnt), 0);
        end
        chk_int("wrap_1", int'(b_instCnt), 1);
        chk_int("wrap_cnt16", int'(instCnt), 17);

        // reset in the middle of a MEM stall aborts the lw
        for (int i = 0; i < 5; i++)
            step(OP_LW, 6'd0, (i < 3) ? 1'b1 : 1'b0, 1'b0, "abort_lw");
        do_reset("abort_reset");
        step(OP_R, 6'd0, 1'b1, 1'b0, "abort_restart");
        chk_int("abort_state", int'(obs.state), 0);
        chk_int("abort_memreq", int'(obs.memReq), 1);

        // random instruction stream
        instr = OP_R;
        trap_cyc = 0;
        for (int i = 0; i < 1500; i++) begin
            if (m_pos == 0) begin
                case ($urandom_range(0, 15))
                    0, 1, 2:  instr = OP_R;
                    3, 4:     instr = OP_ADDI;
                    5, 6, 7:  instr = OP_LW;
                    8, 9:     instr = OP_SW;
                    10, 11:   instr = OP_BEQ;
                    12, 13:   instr = OP_J;
                    default:  instr = 6'($urandom);
                endcase
            end
            step((m_pos == 0) ? 6'($urandom) : instr, 6'($urandom),
                 ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0, 1'($urandom), "rand");
            trap_cyc = (m_phase(instr) == 7) ? trap_cyc + 1 : 0;
            if (trap_cyc > 4 || $urandom_range(0, 199) == 0) begin
                do_reset("rand_reset");
                trap_cyc = 0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
